// File: rtl/burst_data_mem.sv
// Burst-read data memory: single-port array with host writes, a burst reader
// that presents one word per FETCH/PRESENT pair, and a whole-array clear.
module burst_data_mem #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              clr_start,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0] OneLeft = LEN_W'(1);

    typedef enum logic [1:0] {StIdle, StClear, StFetch, StPresent} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // State and burst bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            clr_ptr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            clr_ptr_q <= clr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and next burst/clear pointers
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        clr_ptr_d = clr_ptr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end else if (rd_start && (rd_len != '0)) begin
                    state_d = StFetch;
                    addr_d  = rd_base;
                    cnt_d   = rd_len;
                end
            end
            StClear: begin
                // Pointer wraps back to 0 on the last word
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            StFetch: begin
                state_d = StPresent;
            end
            StPresent: begin
                if (rd_ready) begin
                    if (cnt_q == OneLeft) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StFetch;
                        cnt_d   = cnt_q - 1'b1;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        rd_valid = (state_q == StPresent);
        rd_last  = (state_q == StPresent) && (cnt_q == OneLeft);
        busy     = (state_q != StIdle);
        rd_data  = rd_data_q;
    end

    // Array writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read in FETCH; old contents win over a same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (state_q == StFetch) begin
            rd_data_q <= mem[addr_q];
        end
    end

endmodule

// File: tb/tb_burst_data_mem.sv
// Self-checking bench for burst_data_mem: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_burst_data_mem;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 5;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_start = 1'b0;
    logic [ADDR_W-1:0] rd_base = '0;
    logic [LEN_W-1:0]  rd_len = '0;
    logic              rd_ready = 1'b1;
    logic              clr_start = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    burst_data_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_start  (rd_start),
        .rd_base   (rd_base),
        .rd_len    (rd_len),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .clr_start (clr_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Model memory, clear cycles still owed, and the burst as (next address,
    // words left, whether a word is in flight or on the bus).
    logic [DATA_W-1:0] mm [DEPTH];
    int                m_clr_left;
    bit                m_active, m_fetch, m_show;
    logic [ADDR_W-1:0] m_addr;
    int                m_left;
    logic [DATA_W-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clr_left <= 0;
            m_active   <= 1'b0;
            m_fetch    <= 1'b0;
            m_show     <= 1'b0;
            m_addr     <= '0;
            m_left     <= 0;
            m_data     <= '0;
        end else begin
            if (m_clr_left > 0) begin
                mm[ADDR_W'(DEPTH - m_clr_left)] <= '0;
                m_clr_left <= m_clr_left - 1;
            end else if (wr_en) begin
                mm[wr_addr] <= wr_data;
            end
            if (m_active) begin
                if (m_fetch) begin
                    m_data  <= mm[m_addr];
                    m_fetch <= 1'b0;
                    m_show  <= 1'b1;
                end else if (m_show && rd_ready) begin
                    m_show <= 1'b0;
                    if (m_left == 1) begin
                        m_active <= 1'b0;
                    end else begin
                        m_left  <= m_left - 1;
                        m_addr  <= m_addr + 1'b1;
                        m_fetch <= 1'b1;
                    end
                end
            end else if (m_clr_left == 0) begin
                if (clr_start) begin
                    m_clr_left <= DEPTH;
                end else if (rd_start && rd_len != '0) begin
                    m_active <= 1'b1;
                    m_fetch  <= 1'b1;
                    m_addr   <= rd_base;
                    m_left   <= int'(rd_len);
                end
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_active || m_clr_left != 0));
            check("rd_valid", 32'(rd_valid), 32'(m_show));
            check("rd_last", 32'(rd_last), 32'(m_show && m_left == 1));
            check("rd_data", 32'(rd_data), 32'(m_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_burst(input int base, input int len);
        rd_start = 1'b1;
        rd_base  = ADDR_W'(base);
        rd_len   = LEN_W'(len);
        tick();
        rd_start = 1'b0;
    endtask

    task automatic get_word(output logic [DATA_W-1:0] d, output logic l);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!rd_valid && n < 40);
        if (!rd_valid) check("wait rd_valid", 32'(rd_valid), 32'd1);
        d = rd_data;
        l = rd_last;
    endtask

    task automatic read_word(input int a, output logic [DATA_W-1:0] d);
        logic l;
        start_burst(a, 1);
        get_word(d, l);
        tick();
    endtask

    logic [DATA_W-1:0] d0, d1;
    logic              l0;
    logic [DATA_W-1:0] exp4 [4];
    int                n;
    bit                saw_valid;

    initial begin
        // Reset state
        repeat (2) tick();
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_last", 32'(rd_last), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(i * 32'h010101));

        // Single-word burst: valid two cycles after rd_start
        wr(3, 24'h123456);
        start_burst(3, 1);
        check("single rd_valid early", 32'(rd_valid), 32'd0);
        tick();
        check("single rd_valid", 32'(rd_valid), 32'd1);
        check("single rd_data", 32'(rd_data), 32'h123456);
        check("single rd_last", 32'(rd_last), 32'd1);
        tick();
        check("single busy after", 32'(busy), 32'd0);

        // Wrapping burst
        wr(14, 24'hA);
        wr(15, 24'hB);
        wr(0, 24'hC);
        wr(1, 24'hD);
        exp4[0] = 24'hA;
        exp4[1] = 24'hB;
        exp4[2] = 24'hC;
        exp4[3] = 24'hD;
        start_burst(14, 4);
        for (int k = 0; k < 4; k++) begin
            get_word(d0, l0);
            check("wrap data", 32'(d0), 32'(exp4[k]));
            check("wrap last", 32'(l0), 32'(k == 3));
        end
        tick();

        // Back-pressure holds the word
        rd_ready = 1'b0;
        start_burst(0, 2);
        get_word(d0, l0);
        check("stall word1", 32'(d0), 32'hC);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall valid", 32'(rd_valid), 32'd1);
            check("stall data", 32'(rd_data), 32'(d0));
        end
        rd_ready = 1'b1;
        get_word(d1, l0);
        check("stall word2", 32'(d1), 32'hD);
        check("stall last", 32'(l0), 32'd1);
        tick();

        // Clear wins over rd_start; writes during clear are dropped
        clr_start = 1'b1;
        rd_start  = 1'b1;
        rd_base   = '0;
        rd_len    = LEN_W'(3);
        tick();
        clr_start = 1'b0;
        rd_start  = 1'b0;
        n = 0;
        saw_valid = 1'b0;
        while (busy && n < 40) begin
            wr_en   = (n < 10);
            wr_addr = ADDR_W'(5);
            wr_data = 24'hABCDEF;
            if (rd_valid) saw_valid = 1'b1;
            n++;
            tick();
        end
        wr_en = 1'b0;
        check("clear busy cycles", 32'(n), 32'd16);
        check("clear no rd_valid", 32'(saw_valid), 32'd0);
        start_burst(0, 16);
        for (int k = 0; k < DEPTH; k++) begin
            get_word(d0, l0);
            check("cleared word", 32'(d0), 32'd0);
        end
        tick();

        // Same-edge write and fetch: old data first, new data on re-read
        wr(6, 24'h111111);
        start_burst(6, 1);
        wr(6, 24'h999999);
        check("rbw valid", 32'(rd_valid), 32'd1);
        check("rbw old", 32'(rd_data), 32'h111111);
        tick();
        read_word(6, d0);
        check("rbw new", 32'(d0), 32'h999999);

        // Reset mid-burst
        wr(9, 24'h5A5A5A);
        start_burst(8, 3);
        get_word(d0, l0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset rd_valid", 32'(rd_valid), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset rd_data", 32'(rd_data), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        read_word(9, d0);
        check("survive reset", 32'(d0), 32'h5A5A5A);

        // Reset mid-clear leaves uncleared words intact
        wr(2, 24'h222222);
        wr(15, 24'h0F0F0F);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        read_word(15, d0);
        check("abort clear kept", 32'(d0), 32'h0F0F0F);
        read_word(2, d0);
        check("abort clear zeroed", 32'(d0), 32'd0);

        // Randomized traffic; the compare process does the checking
        for (int c = 0; c < 2000; c++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data   = DATA_W'($urandom);
            rd_start  = ($urandom_range(0, 3) == 0);
            rd_base   = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_len    = LEN_W'($urandom_range(0, 31));
            rd_ready  = ($urandom_range(0, 2) != 0);
            clr_start = ($urandom_range(0, 80) == 0);
            tick();
        end
        wr_en     = 1'b0;
        rd_start  = 1'b0;
        clr_start = 1'b0;
        rd_ready  = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check("drain idle", 32'(busy), 32'd0);
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_data_mem.md
BURST_DATA_MEM -- requirements
Module: burst_data_mem

Interface
REQ-001 Parameter DATA_W, default 24: word width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter LEN_W, default ADDR_W+1: burst-length field width.
REQ-004 clk  in  1: single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 wr_en  in  1: write strobe.
REQ-007 wr_addr  in  ADDR_W: write address.
REQ-008 wr_data  in  DATA_W: write data.
REQ-009 rd_start  in  1: burst-read request, one-cycle pulse.
REQ-010 rd_base  in  ADDR_W: first burst address, sampled with rd_start.
REQ-011 rd_len  in  LEN_W: number of words in the burst, sampled with rd_start.
REQ-012 rd_ready  in  1: consumer accepts the current word.
REQ-013 rd_valid  out  1: rd_data holds a valid burst word.
REQ-014 rd_data  out  DATA_W: burst read data.
REQ-015 rd_last  out  1: the current word is the final word of the burst; asserted only while rd_valid=1.
REQ-016 clr_start  in  1: request to zero the whole array, one-cycle pulse.
REQ-017 busy  out  1: FSM is not in IDLE.

Function
REQ-018 FSM states: IDLE, CLEAR, FETCH, PRESENT.
REQ-019 IDLE, clr_start=1 -> CLEAR with clear pointer = 0; clr_start has priority over rd_start in the same cycle.
REQ-020 IDLE, rd_start=1, rd_len!=0 -> FETCH; rd_base is captured as the address and rd_len as the remaining count.
REQ-021 IDLE, rd_start=1, rd_len=0 -> no state change and no output activity.
REQ-022 rd_start or clr_start arriving while busy=1 is ignored; it is neither queued nor an error.
REQ-023 CLEAR writes 0 to one address per cycle, starting at address 0, for DEPTH cycles, then returns to IDLE; busy=1 throughout.
REQ-024 During CLEAR, wr_en is ignored.
REQ-025 FETCH issues a synchronous array read at the current address, then moves to PRESENT on the next edge.
REQ-026 PRESENT: rd_valid=1 and rd_data is held stable until rd_ready=1; rd_last=1 when the remaining count is 1.
REQ-027 PRESENT with rd_ready=1 and remaining count>1 -> decrement the count, advance the address by 1 (modulo DEPTH), go to FETCH.
REQ-028 PRESENT with rd_ready=1 and remaining count=1 -> IDLE.
REQ-029 Address wrap-around: DEPTH-1 advances to 0; a burst length greater than DEPTH keeps wrapping.
REQ-030 Timing: the first rd_valid comes 2 cycles after the rd_start edge; steady throughput is 1 word per 2 cycles when rd_ready is held at 1.
REQ-031 In IDLE, FETCH and PRESENT, wr_en=1 writes wr_data to mem[wr_addr] on the edge.
REQ-032 A same-edge write and FETCH read to the same address returns the old contents (read-before-write).
REQ-033 Array contents persist through reset; only CLEAR zeroes them.
REQ-034 Outside PRESENT: rd_valid=0 and rd_last=0; rd_data holds its last value.

Reset
REQ-035 rst_n=0 forces, asynchronously: state=IDLE, rd_valid=0, rd_last=0, rd_data=0, busy=0, address/count/clear pointer=0.
REQ-036 Reset mid-burst or mid-clear aborts the operation with no further output; after a mid-clear abort, words not yet cleared keep their prior values.
REQ-037 Array contents are not reset.

Verification
REQ-038 Write 0x123456 to addr 3; burst base=3, len=1, rd_ready=1 -> rd_valid two cycles after rd_start, rd_data=0x123456, rd_last=1, then busy=0.
REQ-039 Fill addr 14,15,0,1 with 0xA,0xB,0xC,0xD; burst base=14, len=4 -> data 0xA,0xB,0xC,0xD in order; rd_last only on 0xD.
REQ-040 Burst len=2 with rd_ready held low 5 cycles on word 1 -> rd_data and rd_valid stable for all 5 cycles; word 2 is delivered after rd_ready rises.
REQ-041 clr_start and rd_start in the same cycle -> busy for 16 cycles, no rd_valid, then all 16 words read back as 0; wr_en during the clear has no effect.
REQ-042 During a burst, write 0x999999 to the address being fetched on the same edge -> old word returned; a re-read returns 0x999999.
REQ-043 rst_n low mid-burst -> rd_valid=0 immediately; the earlier write survives reset and reads back correctly.
